ifetch_buffer: RTL and testbench

- Decoupled instruction-fetch front end between a variable-latency instruction memory and the pipeline's IF/ID register.
- Generates sequential fetch addresses and issues requests under a credit scheme.
- Buffers returned instructions in order and presents them to the decode stage with a valid/ready handshake.
- On a taken branch or jump from the execute stage, flushes all buffered instructions and discards stale in-flight responses.

---
 rtl/ifetch_buffer_pkg.sv | 16 +
 rtl/ifb_fifo.sv | 46 ++++
 rtl/ifetch_buffer.sv | 76 +++++++
 tb/tb_ifetch_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_buffer_pkg.sv
// Shared widths, fetch constants and the buffered-entry layout for the fetch buffer.
package ifetch_buffer_pkg;
  localparam int ADDR_SIZE  = 32;
  localparam int INSTR_SIZE = 32;
  localparam int IFB_DEPTH  = 4;
  localparam logic [ADDR_SIZE-1:0] IFB_PC_STEP = 32'd4;

  typedef struct packed {
    logic [ADDR_SIZE-1:0]  pc;
    logic [INSTR_SIZE-1:0] instr;
  } ifb_entry_t;

  function automatic logic [ADDR_SIZE-1:0] align_pc(input logic [ADDR_SIZE-1:0] a);
    return {a[ADDR_SIZE-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO with single-cycle flush; head is read straight from storage.
module ifb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // flush wins over both push and pop in the same cycle
  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ifetch_buffer.sv
// Decoupled fetch front end: credit-limited sequential requests, in-order response
// buffering with pc tags, and flush/discard of stale responses on redirect.
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int                   DEPTH    = IFB_DEPTH,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [ADDR_SIZE-1:0]  redirectpc,
  output logic                  ireq_valid,
  input  logic                  ireq_ready,
  output logic [ADDR_SIZE-1:0]  ireq_addr,
  input  logic                  irsp_valid,
  input  logic [INSTR_SIZE-1:0] irsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [INSTR_SIZE-1:0] instr,
  output logic [ADDR_SIZE-1:0]  instr_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e               state;
  logic [ADDR_SIZE-1:0] fetchpc;
  logic [CW-1:0]        discard, tag_count, fifo_count, outstanding, discard_redir;
  logic [ADDR_SIZE-1:0] tag_pc;
  logic                 req_fire, rsp_keep;
  ifb_entry_t           push_entry, head;

  // Live tags plus stale responses still owed by memory make up the in-flight total.
  assign outstanding   = tag_count + discard;
  assign discard_redir = outstanding - CW'(irsp_valid);

  assign ireq_valid = !reset && (state == RUN) && !redirect &&
                      (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign ireq_addr  = fetchpc;
  assign req_fire   = ireq_valid && ireq_ready;
  assign rsp_keep   = irsp_valid && !redirect && (discard == '0);

  assign push_entry  = '{pc: tag_pc, instr: irsp_data};
  assign instr_valid = (fifo_count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  ifb_fifo #(.WIDTH(ADDR_SIZE), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .rst(reset), .flush(redirect),
    .push(req_fire), .wdata(fetchpc), .pop(rsp_keep),
    .rdata(tag_pc), .count(tag_count)
  );

  ifb_fifo #(.WIDTH($bits(ifb_entry_t)), .DEPTH(DEPTH)) u_data (
    .clk(clk), .rst(reset), .flush(redirect),
    .push(rsp_keep), .wdata(push_entry), .pop(instr_ready),
    .rdata(head), .count(fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchpc <= RESET_PC;
      discard <= '0;
      state   <= RUN;
    end else if (redirect) begin
      fetchpc <= align_pc(redirectpc);
      discard <= discard_redir;
      state   <= (discard_redir != '0) ? DRAIN : RUN;
    end else begin
      if (req_fire) fetchpc <= fetchpc + IFB_PC_STEP;
      if (irsp_valid && (discard != '0)) discard <= discard - CW'(1);
      if ((state == DRAIN) && (discard == '0)) state <= RUN;
    end
  end
endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer with an in-order variable-latency memory model.
module tb_ifetch_buffer;
  logic        clk = 1'b0;
  logic        reset, redirect, ireq_valid, ireq_ready, irsp_valid;
  logic        instr_valid, instr_ready;
  logic [31:0] redirectpc, ireq_addr, irsp_data, instr, instr_pc;

  int n_pass = 0, n_fail = 0, n_total = 0, cyc = 0;
  int lat = 1;
  bit rnd_lat = 1'b0;
  bit flag;
  int last_due = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] rq[$], dq[$];
  logic [31:0] exp_pc = 32'h0;

  ifetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirectpc(redirectpc),
    .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_addr(ireq_addr),
    .irsp_valid(irsp_valid), .irsp_data(irsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: responses in order, one per cycle, no earlier than `lat` cycles after issue.
  initial begin
    irsp_valid = 1'b0;
    irsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        irsp_valid = 1'b1;
        irsp_data  = memfn(mq_addr[0]);
      end else begin
        irsp_valid = 1'b0;
        irsp_data  = '0;
      end
      @(negedge clk);
      if (reset) begin
        mq_addr.delete(); mq_due.delete(); last_due = 0;
      end else begin
        if (irsp_valid && mq_addr.size() > 0) begin
          void'(mq_addr.pop_front()); void'(mq_due.pop_front());
        end
        if (ireq_valid && ireq_ready) begin
          automatic int l = rnd_lat ? int'($urandom_range(1, 4)) : lat;
          automatic int d = (cyc + l > last_due + 1) ? cyc + l : last_due + 1;
          last_due = d;
          mq_addr.push_back(ireq_addr); mq_due.push_back(d);
          rq.push_back(ireq_addr);
        end
      end
    end
  end

  // Delivery monitor: expected pc restarts at reset/redirect target and steps by 4.
  initial forever begin
    @(negedge clk);
    if (reset) exp_pc = 32'h0;
    else begin
      chk("credit", 32'(int'(u_dut.fifo_count) + int'(u_dut.outstanding) <= 4), 32'd1);
      if (redirect) exp_pc = redirectpc & ~32'h3;
      else if (instr_valid && instr_ready) begin
        dq.push_back(instr_pc);
        chk("deliver_pc", instr_pc, exp_pc);
        chk("deliver_instr", instr, memfn(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  // Redirect to misaligned 0x13, issue 0x10/0x14/0x18 at latency 3, redirect to 0x100
  // in the cycle the 0x10 response returns. Leaves the bench just after that redirect edge.
  task automatic redirect_scenario();
    @(posedge clk); #1 reset = 1; lat = 3; rnd_lat = 0; ireq_ready = 0; instr_ready = 1; redirect = 0;
    @(posedge clk); #1 reset = 0; redirect = 1; redirectpc = 32'h13; rq.delete(); dq.delete();
    @(negedge clk); chk("redir_blocks_req", ireq_valid, 1'b0);
    @(posedge clk); #1 redirect = 0; ireq_ready = 1;
    @(negedge clk); chk("misaligned_addr", ireq_addr, 32'h10); chk("c1_req", ireq_valid, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 redirect = 1; redirectpc = 32'h100;
    @(negedge clk); chk("redir_no_req", ireq_valid, 1'b0);
    @(posedge clk); #1 redirect = 0;
  endtask

  initial begin
    reset = 1; redirect = 0; redirectpc = '0; ireq_ready = 1; instr_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ireq_valid", ireq_valid, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_ireq_addr", ireq_addr, 32'h0);

    // streaming at latency 1
    @(posedge clk); #1 reset = 0; rq.delete(); dq.delete();
    @(negedge clk); chk("p1_req_valid", ireq_valid, 1'b1); chk("p1_addr0", ireq_addr, 32'h0);
    @(negedge clk); chk("p1_no_bypass", instr_valid, 1'b0);
    @(negedge clk); chk("p1_first_valid", instr_valid, 1'b1); chk("p1_first_pc", instr_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin @(negedge clk); chk("p1_b2b", instr_valid, 1'b1); end
    for (int i = 0; i < 4; i++) chk("p1_req_seq", rq[i], 32'(4 * i));

    // decode stall fills the buffer
    @(posedge clk); #1 reset = 1; instr_ready = 0;
    @(posedge clk); #1 reset = 0; rq.delete(); dq.delete();
    repeat (10) @(negedge clk);
    chk("p2_req_count", 32'(rq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("p2_req_seq", rq[i], 32'(4 * i));
    chk("p2_req_stopped", ireq_valid, 1'b0);
    chk("p2_fifo_full", 32'(u_dut.fifo_count), 32'd4);
    chk("p2_head_pc", instr_pc, 32'h0);
    @(posedge clk); #1 instr_ready = 1;
    repeat (16) @(negedge clk);
    chk("p2_enough", 32'(dq.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) chk("p2_drain_order", dq[i], 32'(4 * i));

    // redirect with stale responses in flight
    redirect_scenario();
    @(negedge clk); chk("p3_discard", 32'(u_dut.discard), 32'd2); chk("p3_drain0", ireq_valid, 1'b0);
    @(negedge clk); chk("p3_drain1", ireq_valid, 1'b0);
    @(negedge clk); chk("p3_drain2", ireq_valid, 1'b0);
    @(negedge clk); chk("p3_resume", ireq_valid, 1'b1); chk("p3_resume_addr", ireq_addr, 32'h100);
    repeat (8) @(negedge clk);
    chk("p3_first_pc", dq[0], 32'h100);
    flag = 0; foreach (dq[i]) if (dq[i] < 32'h100) flag = 1;
    chk("p3_no_stale", flag, 1'b0);

    // second redirect while draining
    redirect_scenario();
    @(negedge clk); chk("p4_drain", ireq_valid, 1'b0);
    @(posedge clk); #1 redirect = 1; redirectpc = 32'h200;
    @(negedge clk); chk("p4_discard_before", 32'(u_dut.discard), 32'd1);
    @(posedge clk); #1 redirect = 0;
    @(negedge clk); chk("p4_resume", ireq_valid, 1'b1); chk("p4_resume_addr", ireq_addr, 32'h200);
    repeat (10) @(negedge clk);
    chk("p4_req3", rq[3], 32'h200);
    flag = 0; foreach (rq[i]) if (rq[i] == 32'h100) flag = 1;
    chk("p4_no_0x100", flag, 1'b0);
    chk("p4_first_pc", dq[0], 32'h200);
    flag = 0; foreach (dq[i]) if (dq[i] < 32'h200) flag = 1;
    chk("p4_no_stale", flag, 1'b0);

    // random handshakes, latency and redirects
    @(posedge clk); #1 reset = 1; rnd_lat = 1;
    @(posedge clk); #1 reset = 0; dq.delete();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      ireq_ready  = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 49) == 0);
      redirectpc  = 32'($urandom_range(0, 32'hFFFF));
    end
    @(posedge clk); #1 redirect = 0; ireq_ready = 1; instr_ready = 1; rnd_lat = 0; lat = 1;
    chk("p5_progress", 32'(dq.size() > 100), 32'd1);

    // asynchronous reset between edges
    repeat (12) @(negedge clk);
    chk("p6_streaming", instr_valid, 1'b1);
    @(posedge clk); #3 reset = 1;
    #1;
    chk("p6_async_instr_valid", instr_valid, 1'b0);
    chk("p6_async_ireq_valid", ireq_valid, 1'b0);
    @(posedge clk); #1 reset = 0; rq.delete(); dq.delete();
    @(negedge clk); chk("p6_restart_addr", ireq_addr, 32'h0); chk("p6_restart_valid", ireq_valid, 1'b1);
    repeat (6) @(negedge clk);
    chk("p6_first_pc", dq[0], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
